// File: rtl/ram_stream_reader.sv
// ram_stream_reader
//   Read-side master for a 256x32 synchronous RAM. A start pulse latches
//   base_addr/count; the block then issues count consecutive reads
//   (base, base+STRIDE, ... wrapping modulo 2^AW) and streams the returned
//   words out on a valid/ready interface through a small FIFO. A read is only
//   issued when the FIFO is guaranteed to have room for its data, so
//   back-pressure on m_ready never drops a word.
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   start               request pulse, ignored while busy
//   base_addr, count    transfer descriptor, sampled with start (count=0: no reads)
//   address, WR, Din    RAM master side (read-only: WR and Din tied low)
//   Do                  RAM read data, valid the cycle after address
//   m_data, m_valid     output stream, driven from the FIFO head
//   m_ready             consumer accept
//   busy                high from the cycle after start through the done cycle
//   done                one-cycle completion pulse
//
// States
//   IDLE  | waiting for start
//   READ  | issuing reads while words remain and the FIFO has room
//   DRAIN | all reads issued, waiting for the consumer to empty the FIFO
//   DONE  | one-cycle completion pulse, back to IDLE

module ram_stream_reader #(
    parameter int AW         = 8,
    parameter int DW         = 32,
    parameter int STRIDE     = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [7:0]    count,
    output logic [AW-1:0] address,
    output logic          WR,
    output logic [DW-1:0] Din,
    input  logic [DW-1:0] Do,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          busy,
    output logic          done
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t          state, state_next;
    logic [7:0]      remaining;
    logic [AW-1:0]   next_addr;
    logic [AW-1:0]   last_addr;
    logic            inflight;
    logic            issue;
    logic            room;
    logic            push;
    logic            pop;
    logic [DW-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   fifo_count, fifo_count_next;

    assign WR      = 1'b0;
    assign Din     = '0;
    assign m_valid = (fifo_count != '0);
    assign m_data  = mem[rd_ptr];
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    // RAM data returns one cycle after issue, so the in-flight flag is the push.
    assign push = inflight;
    assign pop  = m_valid & m_ready;

    // A slot freed by this cycle's accept counts as room, which keeps a full
    // word-per-cycle stream going with only two entries.
    assign room = (int'(fifo_count) + int'(inflight) - int'(pop)) < FIFO_DEPTH;

    always_comb begin
        fifo_count_next = fifo_count;
        if (push && !pop)
            fifo_count_next = fifo_count + CW'(1);
        else if (!push && pop)
            fifo_count_next = fifo_count - CW'(1);
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                // A zero-length request passes through DRAIN (already empty)
                // so done lands two cycles after start.
                if (start)
                    state_next = (count == 8'd0) ? DRAIN : READ;
            end
            READ: begin
                if (remaining != 8'd0 && room) begin
                    issue = 1'b1;
                    if (remaining == 8'd1)
                        state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Look at the post-accept occupancy so done follows the last
                // accept by exactly one cycle.
                if (fifo_count_next == '0 && !inflight)
                    state_next = DONE;
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Address is only driven to a new value in an issue cycle; otherwise it
    // holds the last address issued.
    assign address = issue ? next_addr : last_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            remaining  <= 8'd0;
            next_addr  <= '0;
            last_addr  <= '0;
            inflight   <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            state      <= state_next;
            inflight   <= issue;
            fifo_count <= fifo_count_next;

            if (state == IDLE && start) begin
                remaining <= count;
                next_addr <= base_addr;
            end

            if (issue) begin
                remaining <= remaining - 8'd1;
                next_addr <= next_addr + AW'(STRIDE);
                last_addr <= next_addr;
            end

            if (push) begin
                mem[wr_ptr] <= Do;
                wr_ptr      <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end

            if (pop)
                rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
        end
    end

endmodule
